// File: rtl/rundown_counter.sv
// rundown_counter: measures a dual-slope integrating ADC conversion.
// It follows the integrator switch drives and counts the integration (run-up) cycles.
// It then counts the de-integration (run-down) cycles until the synchronized
// comparator changes sign. The result is held until the consumer acknowledges it.
module rundown_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_charge,
  input  logic             charge,
  input  logic             discharge,
  input  logic             discharge_end,
  input  logic             comp_in,
  input  logic             result_ack,
  output logic [CNT_W-1:0] runup_count,
  output logic [CNT_W-1:0] rundown_count,
  output logic             result_valid,
  output logic [1:0]       status,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNUP   = 2'd1,
    RUNDOWN = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [1:0]       ST_OK       = 2'b00;
  localparam logic [1:0]       ST_NO_CROSS = 2'b01;
  localparam logic [1:0]       ST_OVERFLOW = 2'b10;
  localparam logic [1:0]       ST_ABORT    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_s;
  logic                   int_ph, ref_ph, short_ph;
  logic [CNT_W-1:0]       runup_q, runup_nxt;
  logic [CNT_W-1:0]       rundown_q, rundown_nxt;
  logic                   sign_q, sign_nxt;
  logic [1:0]             status_nxt;
  logic                   hold_entry;

  // Comparator synchronizer; only the last stage is ever looked at.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
    end
  end

  assign comp_s = sync_q[SYNC_STAGES-1];

  // Phase decode from the active-low switch drives.
  always_comb begin
    int_ph   = ~input_charge;
    ref_ph   = input_charge & (~charge | ~discharge);
    short_ph = ~discharge_end;
  end

  // Next-state and counter update. Every exit into HOLD also sets the status code.
  always_comb begin
    state_nxt   = state_q;
    runup_nxt   = runup_q;
    rundown_nxt = rundown_q;
    sign_nxt    = sign_q;
    status_nxt  = status;
    case (state_q)
      IDLE: begin
        if (int_ph) begin
          state_nxt   = RUNUP;
          runup_nxt   = CNT_ONE;
          rundown_nxt = '0;
        end
      end
      RUNUP: begin
        if (short_ph) begin
          state_nxt  = HOLD;
          status_nxt = ST_ABORT;
        end else if (int_ph) begin
          if (&runup_q) begin
            state_nxt  = HOLD;
            status_nxt = ST_OVERFLOW;
          end else begin
            runup_nxt = runup_q + CNT_ONE;
          end
        end else if (ref_ph) begin
          state_nxt   = RUNDOWN;
          sign_nxt    = comp_s;
          rundown_nxt = '0;
        end else begin
          state_nxt  = HOLD;
          status_nxt = ST_ABORT;
        end
      end
      RUNDOWN: begin
        if (short_ph) begin
          state_nxt  = HOLD;
          status_nxt = ST_ABORT;
        end else if (comp_s != sign_q) begin
          state_nxt  = HOLD;
          status_nxt = ST_OK;
        end else if (!ref_ph) begin
          state_nxt  = HOLD;
          status_nxt = ST_NO_CROSS;
        end else if (&rundown_q) begin
          state_nxt  = HOLD;
          status_nxt = ST_OVERFLOW;
        end else begin
          rundown_nxt = rundown_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (result_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    hold_entry = (state_nxt == HOLD) && (state_q != HOLD);
  end

  // State, live counters and captured comparator sign.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      runup_q   <= '0;
      rundown_q <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      runup_q   <= runup_nxt;
      rundown_q <= rundown_nxt;
      sign_q    <= sign_nxt;
    end
  end

  // Result outputs latch the post-edge counter values on HOLD entry. The flags are
  // registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      runup_count   <= '0;
      rundown_count <= '0;
      status        <= ST_OK;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (hold_entry) begin
        runup_count   <= runup_nxt;
        rundown_count <= rundown_nxt;
        status        <= status_nxt;
      end
      result_valid <= (state_nxt == HOLD);
      busy         <= (state_nxt == RUNUP) || (state_nxt == RUNDOWN);
    end
  end

endmodule

// File: doc/rundown_counter.md
RUNDOWN_COUNTER -- requirements
Module: rundown_counter

Interface
REQ-001 SHALL provide parameter: CNT_W, 16, width of both count results.
REQ-002 SHALL provide parameter: SYNC_STAGES, 2, comparator synchronizer depth, legal values 2 and above.
REQ-003 SHALL have port: clock  input  1  rising-edge clock, the same domain as the integrator switch controller.
REQ-004 SHALL have port: reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: input_charge  input  1  active-low unknown-input integrate switch drive.
REQ-006 SHALL have port: charge  input  1  active-low reference switch A drive.
REQ-007 SHALL have port: discharge  input  1  active-low reference switch B drive.
REQ-008 SHALL have port: discharge_end  input  1  active-low integrator short/reset switch drive.
REQ-009 SHALL have port: comp_in  input  1  asynchronous integrator zero-crossing comparator output.
REQ-010 SHALL have port: result_ack  input  1  consumer accepts the held result.
REQ-011 SHALL have port: runup_count  output  CNT_W  integration-phase cycle count.
REQ-012 SHALL have port: rundown_count  output  CNT_W  de-integration cycles until crossing.
REQ-013 SHALL have port: result_valid  output  1  result held, waiting for ack.
REQ-014 SHALL have port: status  output  2  00 ok, 01 no crossing, 10 overflow, 11 aborted.
REQ-015 SHALL have port: busy  output  1  high in RUNUP or RUNDOWN.

Function
REQ-016 SHALL synchronize comp_in through SYNC_STAGES flops; comp_s is the last stage and is the only comparator value used.
REQ-017 SHALL decode the phases every cycle from the switch inputs: INT = !input_charge; REF = input_charge && (!charge || !discharge); SHORT = !discharge_end.
REQ-018 SHALL implement the states IDLE, RUNUP, RUNDOWN and HOLD.
REQ-019 IDLE behaviour: when INT=1, go to RUNUP and load the runup counter with 1; otherwise stay in IDLE.
REQ-020 RUNUP transitions, one per cycle, in this priority: SHORT -> HOLD with status 11; INT=1 -> increment; INT=0 with REF=1 -> RUNDOWN, capture sign <= comp_s, rundown counter <= 0; INT=0 with REF=0 -> HOLD with status 11.
REQ-021 RUNDOWN transitions, one per cycle, in this priority: SHORT -> HOLD with status 11; comp_s != sign -> HOLD with status 00 and the count unchanged; REF=0 -> HOLD with status 01; otherwise increment.
REQ-022 Overflow: an increment of a counter that is already all-ones SHALL saturate the counter and go to HOLD with status 10.
REQ-023 On every entry to HOLD, runup_count and rundown_count SHALL latch the live counters; they SHALL change at no other time except reset.
REQ-024 HOLD SHALL drive result_valid=1 and hold the outputs stable; result_ack=1 returns the block to IDLE on the next edge and result_valid drops on that same edge.
REQ-025 INT asserted during HOLD SHALL be ignored and SHALL NOT overwrite the result; a conversion starts only from IDLE.
REQ-026 result_ack outside HOLD SHALL be ignored.
REQ-027 rundown_count SHALL include the synchronizer latency of SYNC_STAGES cycles uncompensated; the consumer subtracts it.
REQ-028 busy SHALL be registered, equal to (state==RUNUP or RUNDOWN).

Reset
REQ-029 reset=1 SHALL force IDLE and clear to zero: both counters, the outputs, result_valid, status, busy, sign and the synchronizer flops.
REQ-030 reset asserted mid-conversion or in HOLD SHALL discard the result without pulsing result_valid.

Verification
REQ-031 Normal conversion: input_charge low for 100 cycles, then discharge low; comp_in toggles 40 cycles after RUNDOWN entry -> runup_count=100, rundown_count=40+SYNC_STAGES (+/-1 per the REQ-021 edge), status 00, result_valid=1.
REQ-032 No crossing: RUNDOWN with comp_in static, discharge released after 30 cycles -> status 01, rundown_count=30.
REQ-033 Overflow: CNT_W=8, input_charge held low for 300 cycles -> runup_count=255, status 10, HOLD entered at cycle 256.
REQ-034 Abort: discharge_end pulsed low during RUNUP -> status 11; input_charge released with no reference active -> status 11 with rundown_count=0.
REQ-035 Handshake: a second INT arrives during HOLD -> the result is unchanged; after result_ack, valid drops next cycle and the new INT starts RUNUP with count 1.
REQ-036 Reset in RUNDOWN -> all outputs 0 on the next edge, with no result_valid pulse.
